// File: rtl/rr_mux41_arbiter.sv
// rtl/rr_mux41_arbiter.sv - round-robin arbiter sharing a 4:1 data mux across four requesters
// Bounded-burst grants; the released requester is always searched last.
module rr_mux41_arbiter #(
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      req,
  input  logic [4*DW-1:0] din,
  input  logic            out_ready,
  output logic [3:0]      gnt,
  output logic [1:0]      s,
  output logic [DW-1:0]   dout,
  output logic            dout_valid,
  output logic [3:0]      ack
);

  localparam int CW = $clog2(MAX_BURST) + 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [1:0]    s_q, s_d;
  logic [3:0]    gnt_q, gnt_d;
  logic [CW-1:0] burst_cnt_q, burst_cnt_d;

  logic          xfer;
  logic          rel;
  logic [2:0]    pick;

  // Returns {found, index}; base+1 has the highest priority, base itself the lowest.
  function automatic logic [2:0] rr_pick(input logic [1:0] base, input logic [3:0] r);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 4; i >= 1; i--) begin
      idx = base + 2'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    s_d         = s_q;
    gnt_d       = gnt_q;
    burst_cnt_d = burst_cnt_q;
    pick        = 3'b000;
    rel         = 1'b0;

    dout = '0;
    for (int k = 0; k < 4; k++) begin
      if (s_q == 2'(k)) dout = din[k*DW +: DW];
    end
    dout_valid = (state_q == BUSY) && req[s_q];
    xfer       = dout_valid && out_ready;
    ack        = gnt_q & {4{xfer}};

    case (state_q)
      IDLE: begin
        pick = rr_pick(ptr_q, req);
        if (pick[2]) begin
          state_d     = BUSY;
          gnt_d       = 4'b0001 << pick[1:0];
          s_d         = pick[1:0];
          burst_cnt_d = '0;
        end
      end
      BUSY: begin
        rel = !req[s_q] || (xfer && (burst_cnt_q == LAST_BEAT));
        if (rel) begin
          // Re-arbitrate in the release cycle so a waiting requester sees no bubble.
          ptr_d       = s_q;
          burst_cnt_d = '0;
          pick        = rr_pick(s_q, req);
          if (pick[2]) begin
            gnt_d = 4'b0001 << pick[1:0];
            s_d   = pick[1:0];
          end else begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
          end
        end else if (xfer) begin
          burst_cnt_d = burst_cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= 2'd3;
      s_q         <= 2'd0;
      gnt_q       <= 4'b0000;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      s_q         <= s_d;
      gnt_q       <= gnt_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign gnt = gnt_q;
  assign s   = s_q;

endmodule

// File: tb/tb_rr_mux41_arbiter.sv
// tb/tb_rr_mux41_arbiter.sv - directed bench for rr_mux41_arbiter with a beat scoreboard
module tb_rr_mux41_arbiter;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    req;
  logic [4*DW-1:0] din;
  logic          out_ready;
  logic [3:0]    gnt;
  logic [1:0]    s;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic [3:0]    ack;

  int checks   = 0;
  int failures = 0;
  int beats    = 0;
  int b0;

  logic [7:0]  dv [4] = '{8'hB0, 8'hA5, 8'hD3, 8'hE4};
  logic [11:0] sb [$];
  logic [11:0] exp_beat;

  rr_mux41_arbiter #(.DW(DW), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst), .req(req), .din(din), .out_ready(out_ready),
    .gnt(gnt), .s(s), .dout(dout), .dout_valid(dout_valid), .ack(ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input int k, input int n);
    for (int i = 0; i < n; i++) sb.push_back({4'b0001 << k, dv[k]});
  endtask

  // Every accepted beat must match the next scoreboard entry; no ack outside a beat.
  always @(negedge clk) begin
    if (dout_valid && out_ready) begin
      beats++;
      exp_beat = (sb.size() != 0) ? sb.pop_front() : 12'hFFF;
      chk("beat_gnt", 32'(gnt), 32'(exp_beat[11:8]));
      chk("beat_dout", 32'(dout), 32'(exp_beat[7:0]));
      chk("beat_ack", 32'(ack), 32'(exp_beat[11:8]));
    end else begin
      chk("no_beat_ack", 32'(ack), 32'd0);
    end
  end

  initial begin
    din = {dv[3], dv[2], dv[1], dv[0]};
    rst = 1'b1; req = 4'b0000; out_ready = 1'b0;

    // Reset holds everything cleared regardless of inputs
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      req = 4'($urandom_range(1, 15)); out_ready = ~out_ready;
      @(negedge clk);
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_s", 32'(s), 32'd0);
      chk("rst_valid", 32'(dout_valid), 32'd0);
      chk("rst_ack", 32'(ack), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0; req = 4'b0000;
    @(negedge clk);
    chk("idle_gnt", 32'(gnt), 32'd0);

    // All requesting: 0,1,2,3,0 with 4 beats each and no gaps
    @(posedge clk); #1;
    push(0, 4); push(1, 4); push(2, 4); push(3, 4); push(0, 4);
    b0 = beats; req = 4'b1111; out_ready = 1'b1;
    @(posedge clk);
    repeat (20) @(negedge clk);
    @(posedge clk); #1;
    req = 4'b0000;
    chk("all_beats", 32'(beats - b0), 32'd20);
    chk("all_sb_empty", 32'(sb.size()), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("all_idle_gnt", 32'(gnt), 32'd0);

    // Single requester 1: re-granted to itself after 4 beats with no gap
    @(posedge clk); #1;
    push(1, 8); b0 = beats; req = 4'b0010;
    @(posedge clk);
    @(negedge clk);
    chk("single_gnt", 32'(gnt), 32'h2);
    chk("single_s", 32'(s), 32'd1);
    chk("single_dout", 32'(dout), 32'hA5);
    chk("single_valid", 32'(dout_valid), 32'd1);
    repeat (7) @(negedge clk);
    @(posedge clk); #1;
    req = 4'b0000;
    chk("single_beats", 32'(beats - b0), 32'd8);
    chk("single_sb_empty", 32'(sb.size()), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("single_idle_gnt", 32'(gnt), 32'd0);

    // Backpressure mid-burst on requester 0; requester 1 follows after exactly 4 beats
    @(posedge clk); #1;
    push(0, 4); push(1, 1); b0 = beats; req = 4'b0011;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(dout_valid), 32'd1);
      chk("bp_ack", 32'(ack), 32'd0);
      chk("bp_gnt", 32'(gnt), 32'h1);
      chk("bp_s", 32'(s), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    req = 4'b0000;
    chk("bp_beats", 32'(beats - b0), 32'd5);
    chk("bp_sb_empty", 32'(sb.size()), 32'd0);
    @(posedge clk);

    // Early drop of requester 2 after two beats; requester 0 takes over
    @(posedge clk); #1;
    push(2, 2); b0 = beats; req = 4'b0101;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #1;
    req = 4'b0001; push(0, 1);
    @(negedge clk);
    chk("drop_valid", 32'(dout_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("drop_gnt", 32'(gnt), 32'h1);
    chk("drop_s", 32'(s), 32'd0);
    @(posedge clk); #1;
    req = 4'b0000;
    chk("drop_beats", 32'(beats - b0), 32'd3);
    chk("drop_sb_empty", 32'(sb.size()), 32'd0);
    @(posedge clk);

    // Asynchronous reset mid-burst, then first grant goes to requester 0
    @(posedge clk); #1;
    push(1, 1); req = 4'b0010;
    @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1; req = 4'b1111;
    #1;
    chk("arst_gnt", 32'(gnt), 32'd0);
    chk("arst_s", 32'(s), 32'd0);
    chk("arst_valid", 32'(dout_valid), 32'd0);
    chk("arst_ack", 32'(ack), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; push(0, 1);
    @(posedge clk);
    @(negedge clk);
    chk("arst_first_gnt", 32'(gnt), 32'h1);
    chk("arst_first_s", 32'(s), 32'd0);
    @(posedge clk); #1;
    req = 4'b0000;
    @(posedge clk);
    @(negedge clk);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    chk("final_gnt", 32'(gnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_mux41_arbiter.md
Name: rr_mux41_arbiter

Overview:
- Round-robin controller that shares a single 4:1 data mux between four requesters.
- Arbitrates among the requests, drives the mux select `s`, and streams the winner's data to one downstream port under a valid/ready handshake.
- Grants are bounded bursts, so no requester can starve the others.
- Sits in front of the existing 4:1 mux datapath; the mux function (dout = din[s]) is implemented inside this block.

Parameters:
- DW, 8, data width per requester.
- MAX_BURST, 4, maximum beats per grant before re-arbitration; legal range is 1 or more.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  request per requester, held high while it has data.
- din  input  4*DW  requester k's data on bits [k*DW +: DW]; held stable while req[k] is high and no ack[k] has been seen.
- out_ready  input  1  downstream accepts a beat.
- gnt  output  4  one-hot registered grant.
- s  output  2  mux select, equal to the index of the granted requester.
- dout  output  DW  muxed data, din[s].
- dout_valid  output  1  beat presented to downstream.
- ack  output  4  one-hot beat-accepted pulse to the granted requester.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
  - Asserting rst immediately clears all state, including mid-burst.
- Reset values:
  - Outputs: gnt=0000, s=00, dout_valid=0, ack=0000.
  - Internal: state=IDLE, ptr=3 (so requester 0 wins first), burst_cnt=0.
- State machine has two states, IDLE and BUSY.
- Arbitration order: search starts at ptr+1 and proceeds modulo 4 (ptr+1, ptr+2, ptr+3, ptr). The first requester found with req high wins.
- IDLE:
  - gnt=0 and dout_valid=0; s holds its last value.
  - If any req bit is high, the winner is registered on the next edge: gnt=onehot(w), s=w, burst_cnt=0, state goes to BUSY.
  - Latency from req to gnt is 1 cycle.
- BUSY (combinational outputs):
  - dout = din[s].
  - dout_valid = req[s].
  - ack = gnt & {4{dout_valid & out_ready}}.
- BUSY transfers:
  - A transfer is dout_valid & out_ready.
  - On each transfer, burst_cnt increments.
  - With out_ready=0, everything holds: gnt, s, burst_cnt and dout_valid all stay unchanged.
- Release condition (evaluated in BUSY), either of:
  - req[s]=0, in which case no ack is issued;
  - a transfer occurs while burst_cnt == MAX_BURST-1.
- On release:
  - ptr <= s.
  - Re-arbitrate in the same cycle from current req, searching from s+1. The released requester is therefore considered last and can be re-granted only if it is the sole requester.
  - If there is a winner: register the new gnt/s, set burst_cnt=0, stay in BUSY. There is no bubble cycle.
  - If there is no winner: go to IDLE, gnt=0.
- MAX_BURST=1: every transfer re-arbitrates.
- burst_cnt width is $clog2(MAX_BURST)+1; it never exceeds MAX_BURST-1.
- Simultaneous requests are resolved purely by the round-robin order; there are no fixed priorities.
- A req rising on a non-granted requester has no effect until the next arbitration point.
- Requester protocol: a requester drops req only after the ack of its final beat. A drop without ack is legal; it ends the grant with no transfer.
- Exactly one gnt bit is high in BUSY, none in IDLE. ack is never asserted outside the granted index.

Test Plan:
1. Reset: hold rst=1, toggle req and out_ready -> gnt=0000, s=00, dout_valid=0, ack=0000 throughout; asserting rst between clock edges clears the outputs before the next edge.
2. Single requester: req=0010, din[15:8]=8'hA5, out_ready=1 -> one cycle later gnt=0010, s=01, dout=8'hA5, dout_valid=1. ack[1] pulses every cycle, and after the 4th beat it is re-granted with no gap (gnt stays 0010).
3. All requesting: req=1111, out_ready=1, MAX_BURST=4 -> grant sequence 0001, 0010, 0100, 1000, 0001 with 4 acks each and zero idle cycles between grants.
4. Backpressure: mid-burst, drive out_ready=0 for 3 cycles -> dout_valid=1, ack=0000, gnt and s unchanged; the burst resumes with its count intact and ends after 4 total acks.
5. Early drop: requester 2 granted, req[2] drops after 2 acks while req[0]=1 -> on the next edge gnt=0001, s=00, and requester 2 receives no third ack.
6. Reset mid-burst: rst pulse during a requester-1 burst -> gnt=0000 and dout_valid=0 immediately. After release with req=1111, the first grant is gnt=0001.
